ula_bist: RTL

Built-in self-test sequencer for the ULA: drives `A`, `B` and `ALUControl` into an external combinational ULA and compares the returned `ALUResult` and `Zero` against a golden vector table. It sits beside the ULA in the datapath, muxed onto the ULA inputs by the top level during test mode, and gives the single-cycle MIPS core a power-on and on-demand ALU check. Results are reported through a start/done handshake with pass/fail status.

---
 rtl/ula_pkg.sv | 62 ++++++
 rtl/ula_bist_rom.sv | 38 +++
 rtl/ula_bist.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared definitions for the ULA built-in self-test.
//   - ALUControl operation codes understood by the ULA
//   - FSM state encoding of the BIST sequencer
//   - golden vector record layout and vector count
// Optional feature macro: ULA_BIST_SLT_SIGNED_EN
//   When defined, the vector table grows from 7 to 9 entries with two extra
//   signed set-less-than vectors.
// ---------------------------------------------------------------------------
package ula_pkg;

    // ALUControl operation codes
    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] SLT = 3'b101;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

`ifdef ULA_BIST_SLT_SIGNED_EN
    localparam int VEC_COUNT = 9;
`else
    localparam int VEC_COUNT = 7;
`endif

    localparam logic [3:0] LAST_IDX    = 4'(VEC_COUNT - 1);
    localparam logic [3:0] NO_FAIL_IDX = 4'hF;

    // One golden vector: operands, opcode and the ULA response we expect
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  code;
        logic [31:0] result;
        logic        zero;
    } vector_t;

    function automatic vector_t make_vector(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [2:0]  code,
        input logic [31:0] result,
        input logic        zero
    );
        vector_t v;
        v.a      = a;
        v.b      = b;
        v.code   = code;
        v.result = result;
        v.zero   = zero;
        return v;
    endfunction

endpackage

// File: rtl/ula_bist_rom.sv
// ---------------------------------------------------------------------------
// ula_bist_rom
// Combinational golden vector table for the ULA self-test.
// Ports:
//   idx  in  4   vector index
//   vec  out     {A, B, ALUControl, expected ALUResult, expected Zero}
// Indices beyond the table return an all-zero record.
// Optional feature macro: ULA_BIST_SLT_SIGNED_EN adds vectors 7 and 8, which
// only pass on a ULA whose SLT compares as signed numbers.
// ---------------------------------------------------------------------------
module ula_bist_rom
    import ula_pkg::*;
(
    input  logic [3:0] idx,
    output vector_t    vec
);

    // Table lookup; code 3'b100 is deliberately an undefined opcode that a
    // correct ULA answers with 0.
    always_comb begin
        vec = '0;
        case (idx)
            4'd0: vec = make_vector(32'd10,        32'd5,         ADD,    32'd15,        1'b0);
            4'd1: vec = make_vector(32'd15,        32'd15,        SUB,    32'd0,         1'b1);
            4'd2: vec = make_vector(32'hFF00_FF00, 32'h0F0F_0F0F, AND,    32'h0F00_0F00, 1'b0);
            4'd3: vec = make_vector(32'h0000_FFFF, 32'hFFFF_0000, OR,     32'hFFFF_FFFF, 1'b0);
            4'd4: vec = make_vector(32'd7,         32'd20,        SLT,    32'd1,         1'b0);
            4'd5: vec = make_vector(32'd25,        32'd10,        SLT,    32'd0,         1'b1);
            4'd6: vec = make_vector(32'd100,       32'd50,        3'b100, 32'd0,         1'b1);
`ifdef ULA_BIST_SLT_SIGNED_EN
            4'd7: vec = make_vector(32'hFFFF_FFFF, 32'd1,         SLT,    32'd1,         1'b0);
            4'd8: vec = make_vector(32'd1,         32'hFFFF_FFFF, SLT,    32'd0,         1'b1);
`endif
            default: vec = '0;
        endcase
    end

endmodule

// File: rtl/ula_bist.sv
// ---------------------------------------------------------------------------
// ula_bist
// Built-in self-test sequencer for the ULA. Walks the golden vector table,
// drives each vector onto the ULA inputs, samples the ULA response and
// reports pass/fail through a start/done handshake.
// Parameters:
//   SETTLE_CYCLES  cycles a vector is held before the response is sampled (1..15)
//   STOP_ON_FAIL   1 ends the run at the first mismatching vector
// Ports:
//   clk             in   1   rising-edge clock
//   reset_n         in   1   synchronous active-low reset
//   start           in   1   run request, honoured in IDLE or DONE
//   A, B            out  32  operands to the ULA
//   ALUControl      out  3   opcode to the ULA
//   ALUResult       in   32  ULA result
//   Zero            in   1   ULA zero flag
//   busy            out  1   vectors are being applied
//   done            out  1   run finished, held until next start or reset
//   pass            out  1   every vector matched (valid with done)
//   fail_count      out  4   mismatching vectors, saturating at 15
//   first_fail_idx  out  4   index of first mismatch, 4'hF when none
// Optional feature macro: ULA_BIST_SLT_SIGNED_EN (extends the vector table,
// handled in ula_pkg and ula_bist_rom).
// ---------------------------------------------------------------------------
module ula_bist
    import ula_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter bit STOP_ON_FAIL  = 1'b0
)
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [2:0]  ALUControl,
    input  logic [31:0] ALUResult,
    input  logic        Zero,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [3:0]  fail_count,
    output logic [3:0]  first_fail_idx
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  idx;
    logic [3:0]  next_idx;
    logic [3:0]  settle_cnt;
    logic [3:0]  next_settle_cnt;

    // Expected response of the vector currently on the ULA inputs
    logic [31:0] exp_result;
    logic        exp_zero;

    logic        start_ok;
    logic        mismatch;
    vector_t     rom_vec;

    logic [31:0] a_next;
    logic [31:0] b_next;
    logic [2:0]  code_next;
    logic [31:0] exp_result_next;
    logic        exp_zero_next;
    logic        busy_next;
    logic        done_next;
    logic        pass_next;
    logic [3:0]  fail_count_next;
    logic [3:0]  first_fail_idx_next;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign mismatch = (state == CHECK) &&
                      ((ALUResult != exp_result) || (Zero != exp_zero));

    // The table is addressed with the index the sequencer will hold after
    // this edge, so the registered operands line up with the new state.
    ula_bist_rom u_rom (
        .idx (next_idx),
        .vec (rom_vec)
    );

    // State register plus all registered outputs. Reset wins over
    // everything, so an aborted run leaves no partial results behind.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= IDLE;
            idx            <= 4'd0;
            settle_cnt     <= 4'd0;
            A              <= 32'd0;
            B              <= 32'd0;
            ALUControl     <= 3'd0;
            exp_result     <= 32'd0;
            exp_zero       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= 4'd0;
            first_fail_idx <= NO_FAIL_IDX;
        end else begin
            state          <= next_state;
            idx            <= next_idx;
            settle_cnt     <= next_settle_cnt;
            A              <= a_next;
            B              <= b_next;
            ALUControl     <= code_next;
            exp_result     <= exp_result_next;
            exp_zero       <= exp_zero_next;
            busy           <= busy_next;
            done           <= done_next;
            pass           <= pass_next;
            fail_count     <= fail_count_next;
            first_fail_idx <= first_fail_idx_next;
        end
    end

    // Next-state logic. DRIVE counts settle cycles; CHECK either advances
    // to the next vector or finishes the run.
    always_comb begin
        next_state      = state;
        next_idx        = idx;
        next_settle_cnt = settle_cnt;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    next_state      = DRIVE;
                    next_idx        = 4'd0;
                    next_settle_cnt = 4'd0;
                end
            end
            DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    next_state = CHECK;
                end else begin
                    next_settle_cnt = settle_cnt + 4'd1;
                end
            end
            CHECK: begin
                if ((idx == LAST_IDX) || (STOP_ON_FAIL && mismatch)) begin
                    next_state = DONE;
                end else begin
                    next_state      = DRIVE;
                    next_idx        = idx + 4'd1;
                    next_settle_cnt = 4'd0;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output logic: values the output registers take at the next edge.
    // Operands are only driven while a vector is in flight; fail tracking
    // is cleared on an accepted start and updated on each CHECK mismatch.
    always_comb begin
        a_next              = 32'd0;
        b_next              = 32'd0;
        code_next           = 3'd0;
        exp_result_next     = 32'd0;
        exp_zero_next       = 1'b0;
        fail_count_next     = fail_count;
        first_fail_idx_next = first_fail_idx;

        busy_next = (next_state == DRIVE) || (next_state == CHECK);
        done_next = (next_state == DONE);

        if (busy_next) begin
            a_next          = rom_vec.a;
            b_next          = rom_vec.b;
            code_next       = rom_vec.code;
            exp_result_next = rom_vec.result;
            exp_zero_next   = rom_vec.zero;
        end

        if (start_ok) begin
            fail_count_next     = 4'd0;
            first_fail_idx_next = NO_FAIL_IDX;
        end else if (mismatch) begin
            if (fail_count != 4'hF) begin
                fail_count_next = fail_count + 4'd1;
            end
            if (first_fail_idx == NO_FAIL_IDX) begin
                first_fail_idx_next = idx;
            end
        end

        pass_next = done_next && (fail_count_next == 4'd0);
    end

endmodule
